adxl355_reader: RTL and testbench

Autonomous SPI master that reads one XYZ sample from the ADXL355 on every rising edge of the SYNC/DRDY clock driven to the sensor. It sits directly downstream of the SYNC generator. Its SPI pins are muxed with the ESP32 passthrough at top level, and `o_busy` selects the owner. Each read is a 10-byte mode-0 transfer: command plus 9 data bytes from XDATA3. The 9 data bytes are emitted as a byte stream toward the logging buffer.

---
 rtl/adxl355_pkg.sv | 22 ++
 rtl/adxl355_reader_if.sv | 24 ++
 rtl/adxl355_spi_byte.sv | 91 +++++++++
 rtl/adxl355_reader.sv | 188 ++++++++++++++++++
 tb/tb_adxl355_reader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adxl355_pkg.sv
// Shared types and constants for the ADXL355 XYZ reader.
package adxl355_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0]  ADXL355_XDATA3    = 8'h08;
    localparam logic        ADXL355_READ      = 1'b1;
    localparam int unsigned ADXL355_XYZ_BYTES = 9;

    // Command byte: 7-bit register address followed by the read flag in bit 0
    function automatic logic [7:0] spi_cmd(input logic [7:0] addr);
        return {addr[6:0], ADXL355_READ};
    endfunction

endpackage

// File: rtl/adxl355_reader_if.sv
// Byte-level handshake between the frame sequencer and the SPI shift engine.
interface adxl355_reader_if;
    logic       start;    // load tx and begin a byte; may coincide with done
    logic [7:0] tx;       // byte to shift out, MSB first
    logic       done;     // last SCLK high half of the current byte ends this cycle
    logic [7:0] rx;       // assembled receive byte
    logic       rx_done;  // one-cycle pulse right after the 8th bit was sampled

    modport master (
        output start,
        output tx,
        input  done,
        input  rx,
        input  rx_done
    );

    modport slave (
        input  start,
        input  tx,
        output done,
        output rx,
        output rx_done
    );
endinterface

// File: rtl/adxl355_spi_byte.sv
// 8-bit SPI mode-0 shift engine: each bit is spi_div clocks low then spi_div clocks high.
// MISO is sampled on the clock where SCLK rises; MOSI advances where SCLK falls.
module adxl355_spi_byte #(
    parameter int unsigned spi_div = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    adxl355_reader_if.slave  bus,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi
);

    localparam logic [7:0] HalfLast = 8'(spi_div - 1);

    logic       active_q, active_d;
    logic       phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       rx_done_q, rx_done_d;
    logic       half_end;

    assign half_end    = active_q && (div_cnt_q == HalfLast);
    assign bus.done    = half_end && phase_q && (bit_cnt_q == 4'd8);
    assign bus.rx      = rx_q;
    assign bus.rx_done = rx_done_q;
    assign sclk        = phase_q;
    assign mosi        = tx_q[7];

    // Next-state: half-period divider, bit counter and shift registers
    always_comb begin
        active_d  = active_q;
        phase_d   = phase_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_done_d = 1'b0;
        if (bus.start) begin
            // A restart on done doubles as the final falling edge of the previous byte
            active_d  = 1'b1;
            phase_d   = 1'b0;
            div_cnt_d = 8'd0;
            bit_cnt_d = 4'd0;
            tx_d      = bus.tx;
        end else if (active_q) begin
            if (half_end) begin
                div_cnt_d = 8'd0;
                if (!phase_q) begin
                    phase_d   = 1'b1;
                    rx_d      = {rx_q[6:0], miso};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    rx_done_d = (bit_cnt_q == 4'd7);
                end else begin
                    phase_d = 1'b0;
                    if (bit_cnt_q == 4'd8) begin
                        active_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            phase_q   <= 1'b0;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 4'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rx_done_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            phase_q   <= phase_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_done_q <= rx_done_d;
        end
    end

endmodule

// File: rtl/adxl355_reader.sv
// Autonomous ADXL355 XYZ reader: one 10-byte SPI read per SYNC rising edge,
// received data bytes streamed out as valid/first/last strobes.
module adxl355_reader
    import adxl355_pkg::*;
#(
    parameter int unsigned spi_div  = 4,
    parameter int unsigned cs_gap   = 8,
    parameter logic [7:0]  reg_addr = ADXL355_XDATA3,
    parameter int unsigned n_data   = ADXL355_XYZ_BYTES
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sync,
    input  logic       i_enable,
    input  logic       i_miso,
    output logic       o_csn,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_busy,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_first,
    output logic       o_last,
    output logic [7:0] o_overrun
);

    localparam logic [7:0]  CmdByte  = spi_cmd(reg_addr);
    localparam logic [15:0] DivLast  = 16'(spi_div - 1);
    localparam logic [15:0] GapLast  = 16'(cs_gap - 1);
    localparam logic [3:0]  LastByte = 4'(n_data);

    adxl355_reader_if u_bus ();

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  byte_idx_q, byte_idx_d;  // 0 is the command slot
    logic        sync_meta_q, sync_sync_q, sync_prev_q;
    logic        sync_rise;
    logic [7:0]  overrun_q;
    logic [7:0]  data_q;
    logic        valid_q, first_q, last_q;
    logic        eng_start;
    logic [7:0]  eng_tx;
    logic        eng_sclk, eng_mosi;
    logic        strobe;

    assign sync_rise   = sync_sync_q && !sync_prev_q;
    assign u_bus.start = eng_start;
    assign u_bus.tx    = eng_tx;
    assign strobe      = u_bus.rx_done && (byte_idx_q != 4'd0);

    adxl355_spi_byte #(
        .spi_div (spi_div)
    ) u_byte (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .bus   (u_bus.slave),
        .miso  (i_miso),
        .sclk  (eng_sclk),
        .mosi  (eng_mosi)
    );

    // Two-flop synchronizer plus edge register for the asynchronous SYNC input
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_meta_q <= 1'b0;
            sync_sync_q <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_meta_q <= i_sync;
            sync_sync_q <= sync_meta_q;
            sync_prev_q <= sync_sync_q;
        end
    end

    // Frame sequencer next-state; feeds the byte engine back-to-back during SHIFT
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        eng_start  = 1'b0;
        eng_tx     = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (sync_rise && i_enable) begin
                    state_d = StSetup;
                    cnt_d   = 16'd0;
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d    = StShift;
                    eng_start  = 1'b1;
                    eng_tx     = CmdByte;
                    byte_idx_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShift: begin
                if (u_bus.done) begin
                    if (byte_idx_q == LastByte) begin
                        state_d = StHold;
                        cnt_d   = 16'd0;
                    end else begin
                        eng_start  = 1'b1;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
            end
            StHold: begin
                if (cnt_q == DivLast) begin
                    state_d = StGap;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame sequencer state registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            byte_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Saturating count of SYNC edges that arrive while a frame is still running
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            overrun_q <= 8'd0;
        end else if (sync_rise && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    // Data strobe one cycle after each data byte's 8th sample; the command slot is silent
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= strobe;
            first_q <= strobe && (byte_idx_q == 4'd1);
            last_q  <= strobe && (byte_idx_q == LastByte);
            if (strobe) begin
                data_q <= u_bus.rx;
            end
        end
    end

    // Pin outputs decoded from the registered state
    always_comb begin
        o_csn  = (state_q == StIdle) || (state_q == StGap);
        o_busy = (state_q != StIdle);
        o_sclk = eng_sclk;
        o_mosi = 1'b0;
        if (state_q == StSetup) begin
            o_mosi = CmdByte[7];
        end else if (state_q == StShift) begin
            o_mosi = eng_mosi;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_first   = first_q;
    assign o_last    = last_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_adxl355_reader.sv
// Bench for adxl355_reader: two instances (spi_div 4 and 2), each with a slave model
// returning A0..A8 after the command byte, plus strobe and pin-timing monitors.
module tb_adxl355_reader;

    logic            clk = 1'b0;
    logic            rstn;
    logic            enable;
    logic [1:0]      sync, miso, csn, sclk, mosi, busy, valid, first, last;
    logic [1:0][7:0] data, ov;
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;
    int              sync_cyc = 0;

    always #5 clk = ~clk;

    // Clock counter; everything else measures time in these units
    always @(posedge clk) cyc++;

    adxl355_reader #(.spi_div(4)) u_dut (
        .i_clk (clk), .i_rstn (rstn), .i_sync (sync[0]), .i_enable (enable), .i_miso (miso[0]),
        .o_csn (csn[0]), .o_sclk (sclk[0]), .o_mosi (mosi[0]), .o_busy (busy[0]),
        .o_data (data[0]), .o_valid (valid[0]), .o_first (first[0]), .o_last (last[0]),
        .o_overrun (ov[0])
    );

    adxl355_reader #(.spi_div(2)) u_dut2 (
        .i_clk (clk), .i_rstn (rstn), .i_sync (sync[1]), .i_enable (enable), .i_miso (miso[1]),
        .o_csn (csn[1]), .o_sclk (sclk[1]), .o_mosi (mosi[1]), .o_busy (busy[1]),
        .o_data (data[1]), .o_valid (valid[1]), .o_first (first[1]), .o_last (last[1]),
        .o_overrun (ov[1])
    );

    // Slave response for frame bit b (0-based): command slot 0, then A0..A8 MSB first
    function automatic logic miso_bit(input int b);
        logic [7:0] v;
        if (b < 8 || b >= 80) return 1'b0;
        v = 8'hA0 + 8'(b / 8 - 1);
        return v[7 - (b % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int Dv = (g == 0) ? 4 : 2;
        int         bitcnt = 0;
        logic [79:0] cap = '0;
        logic       csn_prev = 1'b1;
        int         t_csn = 0, csn_len = 0, csn_falls = 0;
        int         last_sclk = -1, sclk_err = 0;
        int         t_busy = 0, busy_len = 0;
        int         n_strobe = 0, strobe_err = 0, exp_idx = 0, t_last = 0, t_first_off = 0;
        int         flag_err = 0;

        assign miso[g] = miso_bit(bitcnt);

        // CSn framing, MOSI capture and SCLK period
        always @(negedge csn[g] or posedge csn[g] or posedge sclk[g]) begin
            if (csn_prev && !csn[g]) begin
                bitcnt = 0;
                t_csn = cyc;
                csn_falls++;
                last_sclk = -1;
            end else if (!csn_prev && csn[g]) begin
                csn_len = cyc - t_csn;
            end else if (!csn[g] && sclk[g]) begin
                cap = {cap[78:0], mosi[g]};
                bitcnt++;
                if (last_sclk >= 0 && (cyc - last_sclk) != 2 * Dv) sclk_err++;
                last_sclk = cyc;
            end
            csn_prev = csn[g];
        end

        always @(posedge busy[g] or negedge busy[g]) begin
            if (busy[g]) t_busy = cyc;
            else busy_len = cyc - t_busy;
        end

        // Strobe stream checker: expects A0..A8 in order with first/last and fixed spacing
        always @(negedge clk) begin
            if (!rstn) begin
                exp_idx = 0;
            end else if (valid[g]) begin
                n_strobe++;
                if (data[g] != 8'(8'hA0 + exp_idx) || first[g] != (exp_idx == 0) ||
                    last[g] != (exp_idx == 8)) strobe_err++;
                if (exp_idx == 0) t_first_off = cyc - t_csn;
                else if ((cyc - t_last) != 16 * Dv) strobe_err++;
                t_last = cyc;
                exp_idx = (exp_idx == 8) ? 0 : exp_idx + 1;
            end else if (first[g] || last[g]) begin
                flag_err++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_sync(input int g, input int period);
        @(negedge clk);
        sync[g] = 1'b1;
        sync_cyc = cyc;
        repeat (3) @(negedge clk);
        sync[g] = 1'b0;
        repeat (period - 4) @(negedge clk);
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy[g]), 0);
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        int   period;
        int   frames;
        logic en;
        int   exp_frames;
        int   exp_strobes;
        int   exp_ov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int f0, s0, sb;
        vecs[0] = '{700, 10, 1'b1, 10, 90, 0};    // comfortable period
        vecs[1] = '{657, 3, 1'b1, 3, 27, 0};      // edge lands in first IDLE cycle
        vecs[2] = '{656, 2, 1'b1, 1, 9, 1};       // one cycle too early: dropped
        vecs[3] = '{400, 10, 1'b1, 5, 45, 6};     // every second edge dropped
        vecs[4] = '{700, 3, 1'b0, 0, 0, 6};       // disabled: nothing starts
        vecs[5] = '{100, 350, 1'b1, 50, 450, 255}; // 300 drops: saturates

        sync = 2'b00;
        enable = 1'b1;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn", int'(csn[0]), 1);
        check("rst_sclk", int'(sclk[0]), 0);
        check("rst_mosi", int'(mosi[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_data", int'(data[0]), 0);
        check("rst_valid", int'(valid[0]), 0);
        check("rst_first", int'(first[0]), 0);
        check("rst_last", int'(last[0]), 0);
        check("rst_overrun", int'(ov[0]), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame at spi_div 4
        send_sync(0, 10);
        check("sync_to_csn", g_mon[0].t_csn - sync_cyc, 3);
        wait_idle(0, 2000);
        check("csn_low_len", g_mon[0].csn_len, 648);
        check("busy_len", g_mon[0].busy_len, 656);
        check("mosi_cmd", int'(g_mon[0].cap[79:72]), 'h11);
        check("mosi_after_cmd", int'(g_mon[0].cap[71:0] != '0), 0);
        check("single_strobes", g_mon[0].n_strobe, 9);
        check("single_strobe_err", g_mon[0].strobe_err, 0);
        check("first_strobe_off", g_mon[0].t_first_off, 129);
        check("sclk_period", g_mon[0].sclk_err, 0);
        check("single_overrun", int'(ov[0]), 0);

        // Sync-period table
        for (int i = 0; i < 6; i++) begin
            f0 = g_mon[0].csn_falls;
            s0 = g_mon[0].n_strobe;
            enable = vecs[i].en;
            for (int k = 0; k < vecs[i].frames; k++) send_sync(0, vecs[i].period);
            wait_idle(0, 2000);
            enable = 1'b1;
            check($sformatf("vec%0d_frames", i), g_mon[0].csn_falls - f0, vecs[i].exp_frames);
            check($sformatf("vec%0d_strobes", i), g_mon[0].n_strobe - s0, vecs[i].exp_strobes);
            check($sformatf("vec%0d_overrun", i), int'(ov[0]), vecs[i].exp_ov);
            check($sformatf("vec%0d_strobe_err", i), g_mon[0].strobe_err, 0);
        end

        // Reset 200 cycles into a frame
        sb = g_mon[0].n_strobe;
        send_sync(0, 10);
        repeat (193) @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_csn", int'(csn[0]), 1);
        check("midrst_sclk", int'(sclk[0]), 0);
        check("midrst_busy", int'(busy[0]), 0);
        check("midrst_overrun", int'(ov[0]), 0);
        check("midrst_strobes_before", g_mon[0].n_strobe - sb, 2);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (400) @(negedge clk);
        check("midrst_no_more_strobes", g_mon[0].n_strobe - sb, 2);
        sb = g_mon[0].n_strobe;
        send_sync(0, 10);
        wait_idle(0, 2000);
        check("postrst_strobes", g_mon[0].n_strobe - sb, 9);
        check("postrst_strobe_err", g_mon[0].strobe_err, 0);
        check("postrst_csn_len", g_mon[0].csn_len, 648);

        // Enable dropped mid-frame: frame still completes
        sb = g_mon[0].n_strobe;
        send_sync(0, 10);
        repeat (90) @(negedge clk);
        enable = 1'b0;
        wait_idle(0, 2000);
        enable = 1'b1;
        check("endrop_strobes", g_mon[0].n_strobe - sb, 9);
        check("endrop_csn_len", g_mon[0].csn_len, 648);
        check("endrop_strobe_err", g_mon[0].strobe_err, 0);

        // spi_div 2 instance
        send_sync(1, 10);
        check("div2_sync_to_csn", g_mon[1].t_csn - sync_cyc, 3);
        wait_idle(1, 2000);
        check("div2_csn_len", g_mon[1].csn_len, 324);
        check("div2_busy_len", g_mon[1].busy_len, 332);
        check("div2_mosi_cmd", int'(g_mon[1].cap[79:72]), 'h11);
        check("div2_strobes", g_mon[1].n_strobe, 9);
        check("div2_strobe_err", g_mon[1].strobe_err, 0);
        check("div2_first_off", g_mon[1].t_first_off, 65);
        check("div2_sclk_period", g_mon[1].sclk_err, 0);

        check("flags_outside_valid0", g_mon[0].flag_err, 0);
        check("flags_outside_valid1", g_mon[1].flag_err, 0);
        check("sclk_period_all", g_mon[0].sclk_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
